// File: rtl/xbar_pkg.sv
// Shared definitions for the crossbar arbiter slice.
//   lock_e       : per-destination packet lock state (IDLE / LOCKED)
//   rr_wrap_inc  : round-robin pointer increment with wrap at n
package xbar_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_e;

    // Next round-robin start position after index idx, wrapping to 0 at n.
    function automatic int rr_wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/xbar_arbiter_if.sv
// Handshake bundle between the sources/destinations and the crossbar arbiter.
//   src_valid_i / src_dest_i / src_last_i : per-source request, target, last flag
//   src_ready_o                           : per-source transfer strobe
//   dst_valid_o / dst_ready_i / dst_last_o: per-destination handshake and last flag
//   input_select_o                        : per-destination crossbar select
// Modports: slave = arbiter view, master = source/destination side.
interface xbar_arbiter_if #(
    parameter int NumElem = 6
);
    localparam int SelWidth = $clog2(NumElem);

    logic [NumElem-1:0]               src_valid_i;
    logic [NumElem-1:0][SelWidth-1:0] src_dest_i;
    logic [NumElem-1:0]               src_last_i;
    logic [NumElem-1:0]               src_ready_o;
    logic [NumElem-1:0]               dst_valid_o;
    logic [NumElem-1:0]               dst_ready_i;
    logic [NumElem-1:0][SelWidth-1:0] input_select_o;
    logic [NumElem-1:0]               dst_last_o;

    modport slave (
        input  src_valid_i, src_dest_i, src_last_i, dst_ready_i,
        output src_ready_o, dst_valid_o, input_select_o, dst_last_o
    );

    modport master (
        output src_valid_i, src_dest_i, src_last_i, dst_ready_i,
        input  src_ready_o, dst_valid_o, input_select_o, dst_last_o
    );

endinterface

// File: rtl/xbar_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : NumElem-bit request vector
//   ptr   : index at which the search starts (highest priority)
//   grant : one-hot grant of the first requester at or after ptr (with wrap)
//   idx   : binary index of the granted requester (0 when nothing requests)
module rr_arbiter #(
    parameter int NumElem = 6
) (
    input  logic [NumElem-1:0]         req,
    input  logic [$clog2(NumElem)-1:0] ptr,
    output logic [NumElem-1:0]         grant,
    output logic [$clog2(NumElem)-1:0] idx
);
    localparam int SelWidth = $clog2(NumElem);

    int  cand;
    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < NumElem; k++) begin
            // Modulo keeps the candidate in range even for a corrupted ptr.
            cand = (int'(ptr) + k) % NumElem;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = SelWidth'(cand);
            end
        end
    end

endmodule

// File: rtl/xbar_arbiter.sv
// Crossbar control stage: per-destination round-robin arbitration with
// packet locking, producing crossbar selects, destination valids/lasts and
// source readies.
//   clk_i, rst_i : clock and synchronous active-high reset
//   bus          : xbar_arbiter_if slave modport (all handshake signals)
//   err_o        : sticky flag, a request to a destination >= NumElem was seen
module xbar_arbiter
    import xbar_pkg::*;
#(
    parameter int NumElem = 6
) (
    input  logic           clk_i,
    input  logic           rst_i,
    xbar_arbiter_if.slave  bus,
    output logic           err_o
);
    localparam int SelWidth = $clog2(NumElem);

    logic [SelWidth-1:0]               rr_ptr_reg [NumElem];
    logic [SelWidth-1:0]               owner_reg  [NumElem];
    lock_e                             lock_reg   [NumElem];
    logic                              err_reg, err_next;

    logic [NumElem-1:0][NumElem-1:0]   req;        // req[dst][src]
    logic [NumElem-1:0][SelWidth-1:0]  sel;
    logic [NumElem-1:0]                valid;
    logic [NumElem-1:0]                last;
    logic [NumElem-1:0]                fire;
    logic [NumElem-1:0]                src_ready;

    // Out-of-range destinations match no j, so they are never granted.
    always_comb begin
        req = '0;
        for (int j = 0; j < NumElem; j++) begin
            for (int i = 0; i < NumElem; i++) begin
                req[j][i] = bus.src_valid_i[i] && (int'(bus.src_dest_i[i]) == j);
            end
        end
    end

    always_comb begin
        err_next = err_reg;
        for (int i = 0; i < NumElem; i++) begin
            if (bus.src_valid_i[i] && (int'(bus.src_dest_i[i]) >= NumElem)) begin
                err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end

    for (genvar gi = 0; gi < NumElem; gi++) begin : g_dst
        logic [NumElem-1:0]  win_grant;
        logic [SelWidth-1:0] win_idx;
        logic                locked;

        rr_arbiter #(.NumElem(NumElem)) u_rr (
            .req   (req[gi]),
            .ptr   (rr_ptr_reg[gi]),
            .grant (win_grant),
            .idx   (win_idx)
        );

        assign locked     = (lock_reg[gi] == LOCKED);
        assign sel[gi]    = locked ? owner_reg[gi] : win_idx;
        // A locked destination stalls while its owner is not valid.
        assign valid[gi]  = locked ? req[gi][owner_reg[gi]] : |win_grant;
        assign last[gi]   = valid[gi] & bus.src_last_i[sel[gi]];
        assign fire[gi]   = valid[gi] & bus.dst_ready_i[gi];

        // Idle destinations keep pointing at the last owner so the
        // crossbar select does not toggle without traffic.
        assign bus.input_select_o[gi] = rst_i     ? '0      :
                                        valid[gi] ? sel[gi] : owner_reg[gi];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                rr_ptr_reg[gi] <= '0;
                owner_reg[gi]  <= '0;
                lock_reg[gi]   <= IDLE;
            end else if (fire[gi]) begin
                owner_reg[gi] <= sel[gi];
                if (last[gi]) begin
                    lock_reg[gi]   <= IDLE;
                    rr_ptr_reg[gi] <= SelWidth'(rr_wrap_inc(int'(sel[gi]), NumElem));
                end else begin
                    lock_reg[gi]   <= LOCKED;
                end
            end
        end
    end

    // Each source targets a single destination, so at most one fire matches.
    always_comb begin
        src_ready = '0;
        for (int j = 0; j < NumElem; j++) begin
            for (int i = 0; i < NumElem; i++) begin
                if (fire[j] && (int'(sel[j]) == i)) begin
                    src_ready[i] = 1'b1;
                end
            end
        end
    end

    assign bus.src_ready_o = rst_i ? '0 : src_ready;
    assign bus.dst_valid_o = rst_i ? '0 : valid;
    assign bus.dst_last_o  = rst_i ? '0 : last;
    assign err_o           = rst_i ? 1'b0 : err_reg;

endmodule

// File: tb/tb_xbar_arbiter.sv
module tb_xbar_arbiter;

    localparam int NumElem = 6;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic err_o;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    xbar_arbiter_if #(.NumElem(NumElem)) bus ();

    xbar_arbiter #(.NumElem(NumElem)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus),
        .err_o (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; prints one line for the transaction of this cycle.
    task automatic tick();
        $display("cycle %0d: src_valid=%b src_ready=%b dst_valid=%b dst_last=%b err=%b",
                 cycle, bus.src_valid_i, bus.src_ready_o, bus.dst_valid_o, bus.dst_last_o, err_o);
        cycle++;
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_src();
        bus.src_valid_i = '0;
        bus.src_last_i  = '0;
        bus.src_dest_i  = '0;
    endtask

    task automatic drive(input int s, input int d, input logic lst);
        bus.src_valid_i[s] = 1'b1;
        bus.src_dest_i[s]  = 3'(d);
        bus.src_last_i[s]  = lst;
    endtask

    initial begin
        bus.dst_ready_i = '1;
        bus.src_valid_i = '1;
        bus.src_last_i  = '1;
        for (int i = 0; i < NumElem; i++) bus.src_dest_i[i] = 3'd2;

        // Reset with every source requesting
        @(posedge clk_i);
        #1;
        check("rst_src_ready", 32'(bus.src_ready_o), 32'h0);
        check("rst_dst_valid", 32'(bus.dst_valid_o), 32'h0);
        check("rst_dst_last", 32'(bus.dst_last_o), 32'h0);
        check("rst_input_select", 32'(bus.input_select_o), 32'h0);
        check("rst_err", 32'(err_o), 32'h0);
        tick();
        rst_i = 1'b0;
        #1;
        check("post_rst_dst_valid", 32'(bus.dst_valid_o), 32'b000100);
        check("post_rst_src_ready", 32'(bus.src_ready_o), 32'b000001);
        check("post_rst_sel2", 32'(bus.input_select_o[2]), 32'd0);
        tick();
        check("post_rst_second", 32'(bus.src_ready_o), 32'b000010);
        clear_src();
        tick();

        // Round robin on dest 0: 1, 3, 4, 1
        drive(1, 0, 1'b1);
        drive(3, 0, 1'b1);
        drive(4, 0, 1'b1);
        #1;
        check("rr_ready_a", 32'(bus.src_ready_o), 32'b000010);
        check("rr_sel_a", 32'(bus.input_select_o[0]), 32'd1);
        tick();
        check("rr_ready_b", 32'(bus.src_ready_o), 32'b001000);
        check("rr_sel_b", 32'(bus.input_select_o[0]), 32'd3);
        tick();
        check("rr_ready_c", 32'(bus.src_ready_o), 32'b010000);
        check("rr_sel_c", 32'(bus.input_select_o[0]), 32'd4);
        tick();
        check("rr_ready_d", 32'(bus.src_ready_o), 32'b000010);
        check("rr_sel_d", 32'(bus.input_select_o[0]), 32'd1);
        tick();
        clear_src();
        #1;
        check("idle_sel_hold", 32'(bus.input_select_o[0]), 32'd1);
        check("idle_dst_valid", 32'(bus.dst_valid_o), 32'h0);
        tick();

        // Lock: source 2 sends 3 beats to dest 1, source 5 waits
        drive(2, 1, 1'b0);
        drive(5, 1, 1'b1);
        #1;
        check("lock_beat1", 32'(bus.src_ready_o), 32'b000100);
        check("lock_beat1_last", 32'(bus.dst_last_o), 32'h0);
        tick();
        bus.src_valid_i[2] = 1'b0;
        #1;
        check("lock_bubble_ready", 32'(bus.src_ready_o), 32'h0);
        check("lock_bubble_valid", 32'(bus.dst_valid_o), 32'h0);
        check("lock_bubble_sel", 32'(bus.input_select_o[1]), 32'd2);
        tick();
        bus.src_valid_i[2] = 1'b1;
        #1;
        check("lock_beat2", 32'(bus.src_ready_o), 32'b000100);
        tick();
        bus.src_last_i[2] = 1'b1;
        #1;
        check("lock_beat3", 32'(bus.src_ready_o), 32'b000100);
        check("lock_beat3_last", 32'(bus.dst_last_o), 32'b000010);
        tick();
        bus.src_valid_i[2] = 1'b0;
        #1;
        check("lock_then_src5", 32'(bus.src_ready_o), 32'b100000);
        check("lock_then_sel5", 32'(bus.input_select_o[1]), 32'd5);
        tick();
        clear_src();
        tick();

        // Backpressure on dest 3
        bus.dst_ready_i[3] = 1'b0;
        drive(0, 3, 1'b1);
        for (int n = 0; n < 4; n++) begin
            #1;
            check("bp_dst_valid", 32'(bus.dst_valid_o), 32'b001000);
            check("bp_src_ready", 32'(bus.src_ready_o), 32'h0);
            check("bp_sel3", 32'(bus.input_select_o[3]), 32'd0);
            tick();
        end
        bus.dst_ready_i[3] = 1'b1;
        #1;
        check("bp_release", 32'(bus.src_ready_o), 32'b000001);
        tick();
        clear_src();
        tick();

        // Parallel fires
        drive(0, 5, 1'b1);
        drive(1, 4, 1'b1);
        drive(2, 3, 1'b1);
        #1;
        check("par_src_ready", 32'(bus.src_ready_o), 32'b000111);
        check("par_dst_valid", 32'(bus.dst_valid_o), 32'b111000);
        check("par_sel5", 32'(bus.input_select_o[5]), 32'd0);
        check("par_sel4", 32'(bus.input_select_o[4]), 32'd1);
        check("par_sel3", 32'(bus.input_select_o[3]), 32'd2);
        tick();
        clear_src();
        tick();

        // Out-of-range destination
        check("err_before", 32'(err_o), 32'h0);
        drive(4, 7, 1'b1);
        #1;
        check("err_no_grant", 32'(bus.src_ready_o), 32'h0);
        check("err_no_valid", 32'(bus.dst_valid_o), 32'h0);
        check("err_same_cycle", 32'(err_o), 32'h0);
        tick();
        check("err_set", 32'(err_o), 32'h1);
        check("err_still_no_grant", 32'(bus.src_ready_o), 32'h0);
        clear_src();
        tick();
        tick();
        check("err_sticky", 32'(err_o), 32'h1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        check("err_cleared", 32'(err_o), 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
